// File: rtl/mz_pulse_sequencer.sv
// mz_pulse_sequencer: RF pulse sequencer for the interferometry control path.
// A rising edge on trig starts one burst, framed by rf-low pre and post delays:
//   pi/2 - gap - (pi - gap) x N - pi/2
// busy covers the whole burst. done pulses for one cycle on normal completion.
// abort returns to idle without done. phase exposes the state code for debug.
`timescale 1ns/1ps
module mz_pulse_sequencer #(
  parameter int CNT_W       = 32,
  parameter int ECHO_W      = 4,
  parameter int PRE_CYCLES  = 400,
  parameter int PI2_CYCLES  = 333,
  parameter int PI_CYCLES   = 666,
  parameter int GAP_CYCLES  = 66600,
  parameter int POST_CYCLES = 33300
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic [ECHO_W-1:0] n_echo,
  input  logic              abort,
  output logic              rf,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase
);

  // A zero duration would make a state last 2^CNT_W cycles instead of zero.
  if (PRE_CYCLES < 1 || PI2_CYCLES < 1 || PI_CYCLES < 1 ||
      GAP_CYCLES < 1 || POST_CYCLES < 1) begin : g_bad_duration
    $error("mz_pulse_sequencer: every duration parameter must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_P2A  = 3'd2,
    S_GAP  = 3'd3,
    S_PI   = 3'd4,
    S_P2B  = 3'd5,
    S_POST = 3'd6
  } state_t;

  // Terminal counter values: a state of duration D counts 0..D-1.
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PI2_LAST  = CNT_W'(PI2_CYCLES - 1);
  localparam logic [CNT_W-1:0] PI_LAST   = CNT_W'(PI_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ECHO_W-1:0] echo_q, echo_d;
  logic [CNT_W-1:0]  last_cnt;
  logic              done_d;
  logic              rf_d;
  logic              trig_s1, trig_s2, trig_prev, start_q;

  // Trigger synchroniser and registered rising-edge detector. All three flops
  // reset high, so a trig held high through reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1   <= 1'b1;
      trig_s2   <= 1'b1;
      trig_prev <= 1'b1;
      start_q   <= 1'b0;
    end else begin
      trig_s1   <= trig;
      trig_s2   <= trig_s1;
      trig_prev <= trig_s2;
      start_q   <= trig_s2 & ~trig_prev;
    end
  end

  // Select the terminal count of the current state.
  always_comb begin
    last_cnt = '0;
    case (state_q)
      S_PRE:   last_cnt = PRE_LAST;
      S_P2A:   last_cnt = PI2_LAST;
      S_GAP:   last_cnt = GAP_LAST;
      S_PI:    last_cnt = PI_LAST;
      S_P2B:   last_cnt = PI2_LAST;
      S_POST:  last_cnt = POST_LAST;
      default: last_cnt = '0;
    endcase
  end

  // Next-state, counter and echo bookkeeping. Abort beats any transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    echo_d  = echo_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (start_q) begin
        state_d = S_PRE;
        echo_d  = n_echo;
      end
    end else if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      echo_d  = '0;
    end else if (cnt_q == last_cnt) begin
      cnt_d = '0;
      case (state_q)
        S_PRE:  state_d = S_P2A;
        S_P2A:  state_d = S_GAP;
        S_GAP:  state_d = (echo_q != '0) ? S_PI : S_P2B;
        S_PI: begin
          state_d = S_GAP;
          echo_d  = echo_q - ECHO_W'(1);
        end
        S_P2B:  state_d = S_POST;
        S_POST: begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // rf is high only in the three pulse states.
  always_comb begin
    rf_d = (state_d == S_P2A) || (state_d == S_PI) || (state_d == S_P2B);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      echo_q  <= '0;
      rf      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      echo_q  <= echo_d;
      rf      <= rf_d;
      busy    <= (state_d != S_IDLE);
      done    <= done_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_mz_pulse_sequencer.sv
// Testbench for mz_pulse_sequencer. The monitor turns rf/busy/done activity
// into observations (segment lengths, busy length, pi-state cycles, done at
// busy fall); directed tests push the hand-computed observations they expect.
`timescale 1ns/1ps
module tb_mz_pulse_sequencer;

  localparam int PRE  = 4;
  localparam int PI2  = 3;
  localparam int PI   = 6;
  localparam int GAP  = 10;
  localparam int POST = 5;

  localparam logic [3:0] T_LO    = 4'd1;
  localparam logic [3:0] T_HI    = 4'd2;
  localparam logic [3:0] T_BUSY  = 4'd3;
  localparam logic [3:0] T_PIC   = 4'd4;
  localparam logic [3:0] T_DONE  = 4'd5;
  localparam logic [3:0] T_STRAY = 4'd6;

  // ---------------- clock / reset ----------------
  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       trig   = 1'b0;
  logic       abort  = 1'b0;
  logic [3:0] n_echo = 4'd0;
  logic       rf, busy, done;
  logic [2:0] phase;

  always #5 clk = ~clk;

  mz_pulse_sequencer #(
    .CNT_W(32), .ECHO_W(4), .PRE_CYCLES(PRE), .PI2_CYCLES(PI2),
    .PI_CYCLES(PI), .GAP_CYCLES(GAP), .POST_CYCLES(POST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .n_echo(n_echo), .abort(abort),
    .rf(rf), .busy(busy), .done(done), .phase(phase)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] t, input int v);
    exp_q.push_back({t, v[27:0]});
  endtask

  // Full sequence with n echoes; busy_total is the hand-computed busy length.
  task automatic push_seq(input int n, input int busy_total);
    push(T_LO, PRE);
    push(T_HI, PI2);
    for (int i = 0; i < n; i++) begin
      push(T_LO, GAP);
      push(T_HI, PI);
    end
    push(T_LO, GAP);
    push(T_HI, PI2);
    push(T_BUSY, busy_total);
    push(T_PIC, n * PI);
    push(T_DONE, 1);
  endtask

  task automatic observe(input logic [3:0] t, input int v);
    logic [31:0] got, exp;
    got = {t, v[27:0]};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: unexpected observation type %0d value %0d", t, v);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL scoreboard: got type %0d value %0d, expected type %0d value %0d",
                 t, v, exp[31:28], exp[27:0]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_rf = 1'b0, prev_busy = 1'b0;
  int   busy_len = 0, hi_len = 0, lo_len = 0, pi_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (!prev_busy && busy) begin
        busy_len = 1;
        lo_len   = rf ? 0 : 1;
        hi_len   = rf ? 1 : 0;
        pi_cnt   = (phase == 3'd4) ? 1 : 0;
      end else if (busy) begin
        busy_len++;
        if (phase == 3'd4) pi_cnt++;
        if (rf) begin
          if (!prev_rf) begin observe(T_LO, lo_len); hi_len = 1; end
          else hi_len++;
        end else begin
          if (prev_rf) begin observe(T_HI, hi_len); lo_len = 1; end
          else lo_len++;
        end
      end else if (prev_busy) begin
        if (prev_rf) observe(T_HI, hi_len);
        observe(T_BUSY, busy_len);
        observe(T_PIC, pi_cnt);
        observe(T_DONE, int'(done));
      end
      if (done && !(prev_busy && !busy)) observe(T_STRAY, 0);
      if (rf && !busy) observe(T_STRAY, 1);
      prev_rf   = rf;
      prev_busy = busy;
    end else begin
      prev_rf   = 1'b0;
      prev_busy = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_trig(input int hi_cycles);
    trig = 1'b1;
    repeat (hi_cycles) @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int budget, input string name);
    int i;
    i = 0;
    while (busy !== val && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, busy, val);
  endtask

  task automatic wait_phase(input logic [2:0] val, input int budget, input string name);
    int i;
    i = 0;
    while (phase !== val && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, phase, val);
  endtask

  task automatic run_full(input int n, input int busy_total, input string name);
    n_echo = n[3:0];
    push_seq(n, busy_total);
    pulse_trig(2);
    wait_busy(1'b1, 10, {name, "_start"});
    wait_busy(1'b0, 200, {name, "_end"});
    repeat (3) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int busy_seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rf", rf, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_phase", phase, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // 1: one echo, with start latency checked against edge k
    n_echo = 4'd1;
    push_seq(1, 41);
    trig = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_busy_before_k3", busy, 0);
    @(negedge clk);
    check("t1_busy_after_k3", busy, 1);
    check("t1_phase_after_k3", phase, 1);
    trig = 1'b0;
    wait_busy(1'b0, 200, "t1_end");
    repeat (3) @(negedge clk);

    // 2: Ramsey, N = 0
    run_full(0, 25, "t2");

    // 3: n_echo changed during PRE has no effect
    n_echo = 4'd3;
    push_seq(3, 73);
    pulse_trig(2);
    wait_phase(3'd1, 10, "t3_pre");
    n_echo = 4'd0;
    wait_busy(1'b0, 200, "t3_end");
    repeat (3) @(negedge clk);

    // 4: trig held high ~200 cycles with an extra edge during GAP
    n_echo = 4'd1;
    push_seq(1, 41);
    trig = 1'b1;
    wait_phase(3'd3, 30, "t4_gap");
    trig = 1'b0;
    repeat (3) @(negedge clk);
    trig = 1'b1;
    repeat (180) @(negedge clk);
    trig = 1'b0;
    check("t4_single_sequence", exp_q.size(), 0);
    repeat (4) @(negedge clk);
    run_full(1, 41, "t4_second");

    // 5: abort in the second GAP
    n_echo = 4'd1;
    push(T_LO, PRE);
    push(T_HI, PI2);
    push(T_LO, GAP);
    push(T_HI, PI);
    push(T_BUSY, 26);
    push(T_PIC, PI);
    push(T_DONE, 0);
    pulse_trig(2);
    wait_phase(3'd4, 60, "t5_pi");
    wait_phase(3'd3, 20, "t5_gap2");
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_abort_rf", rf, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_phase", phase, 0);
    repeat (3) @(negedge clk);
    run_full(1, 41, "t5_after");

    // 6: asynchronous reset mid-PI with trig held high across release
    n_echo = 4'd1;
    push(T_LO, PRE);
    push(T_HI, PI2);
    push(T_LO, GAP);
    trig = 1'b1;
    wait_busy(1'b1, 10, "t6_start");
    wait_phase(3'd4, 40, "t6_pi");
    repeat (2) @(negedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("t6_async_rf", rf, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_phase", phase, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    busy_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("t6_no_start_while_high", busy_seen, 0);
    trig = 1'b0;
    repeat (4) @(negedge clk);
    run_full(1, 41, "t6_after");

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
